riscv_reg_file: RTL and testbench
=================================

Name: riscv_reg_file

Overview:
- RV32I integer register file: 32 x 32-bit architectural registers (x0..x31).
- Two asynchronous read ports and one synchronous write port.
- Sits in the decode stage of the pipelined CPU. The read ports feed rs1/rs2 operands; the write port is driven by the writeback stage.
- x0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports
- ADDR_WIDTH, 5, register index width; register count is 2**ADDR_WIDTH (32)

Ports:
- clk_i  input  1  system clock; all writes occur on the rising edge
- reset_i  input  1  asynchronous, active-low reset; clears all registers
- a1_i  input  ADDR_WIDTH  read port 1 register index (rs1)
- a2_i  input  ADDR_WIDTH  read port 2 register index (rs2)
- a3_i  input  ADDR_WIDTH  write port register index (rd)
- wd3_i  input  DATA_WIDTH  write data
- we3_i  input  1  write enable, active-high
- reg_data_1_o  output  DATA_WIDTH  contents of register a1_i
- reg_data_2_o  output  DATA_WIDTH  contents of register a2_i

Behaviour:
- Storage: registers x1..x31, each DATA_WIDTH flops. x0 has no storage.
- Reset:
  - reset_i low asynchronously forces x1..x31 to 0, regardless of clk_i.
  - While reset_i is low, writes are blocked and both outputs read 0 for every address.
  - On release, registers hold 0 until the first enabled write.
- Write:
  - On the rising edge of clk_i, with reset_i high, we3_i = 1 and a3_i != 0: register[a3_i] <= wd3_i.
  - we3_i = 0: no register changes, whatever a3_i and wd3_i are.
  - a3_i = 0 with we3_i = 1: the write is silently discarded and x0 stays 0.
- Read:
  - Purely combinational, zero latency. reg_data_1_o = register[a1_i] and reg_data_2_o = register[a2_i].
  - Either index = 0 yields 0.
  - The outputs follow address changes within the same cycle.
- Read-after-write timing:
  - A written value becomes visible on the read ports immediately after the capturing rising edge, with no extra cycle.
  - There is no same-cycle internal bypass of wd3_i before the edge. The pipeline hazard unit handles forwarding.
- Dual-port reads:
  - Both ports may address the same register simultaneously, and both return the identical value.
  - A read and a write to the same register in the same cycle: the read shows the old value until the edge, then the new value.
- Reset mid-operation: an assertion coinciding with a write edge resolves as reset, so the register ends at 0.
- No X propagation: every output is defined for every input index after reset.

Test Plan:
- Reset check:
  - Stimulus: hold reset_i low for one cycle, release, then sweep a1_i = a2_i = 0..31, one per cycle, with we3_i = 0.
  - Required response: reg_data_1_o = reg_data_2_o = 0 for all 32 indices.
- Write sweep:
  - Stimulus: we3_i = 1; each cycle set a1_i = a2_i = a3_i = wd3_i = i for i = 0..31.
  - Required response: after each rising edge, both outputs = i for i >= 1, and 0 for i = 0.
- Write-enable off:
  - Stimulus: we3_i = 0; sweep a1_i = a2_i = a3_i = i with wd3_i = 100 (decimal).
  - Required response: outputs still = i (0 for x0); no register ever reads 100.
- Zero register:
  - Stimulus: we3_i = 1, a3_i = 0, wd3_i = 1, a1_i = a2_i = 0 across a rising edge.
  - Required response: both outputs remain 0.
- Independent ports:
  - Stimulus: after the write sweep, set a1_i = 5 and a2_i = 31.
  - Required response: reg_data_1_o = 5 and reg_data_2_o = 31 with no clock edge needed.
- Async reset mid-run:
  - Stimulus: after the write sweep, pulse reset_i low between clock edges.
  - Required response: outputs drop to 0 immediately without waiting for a clock edge, and all registers read 0 afterwards.

Source files
------------

// File: rtl/riscv_reg_file.sv
// riscv_reg_file: RV32I register file, 31 stored registers plus hardwired x0,
// two combinational read ports and one rising-edge write port.
module riscv_reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [ADDR_WIDTH-1:0] a1_i,
  input  logic [ADDR_WIDTH-1:0] a2_i,
  input  logic [ADDR_WIDTH-1:0] a3_i,
  input  logic [DATA_WIDTH-1:0] wd3_i,
  input  logic                  we3_i,
  output logic [DATA_WIDTH-1:0] reg_data_1_o,
  output logic [DATA_WIDTH-1:0] reg_data_2_o
);
  localparam int N = 2 ** ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] regs_q [1:N-1];
  logic [DATA_WIDTH-1:0] regs_d [1:N-1];
  logic [DATA_WIDTH-1:0] rd_view [N];
  always_comb begin
    for (int i = 1; i < N; i++)
      regs_d[i] = (we3_i && a3_i == ADDR_WIDTH'(i)) ? wd3_i : regs_q[i];
  end
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 1; i < N; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 1; i < N; i++) regs_q[i] <= regs_d[i];
    end
  end
  // x0 has no storage; the read view supplies a constant zero in its slot
  assign rd_view[0] = '0;
  for (genvar g = 1; g < N; g++) begin : g_view
    assign rd_view[g] = regs_q[g];
  end
  assign reg_data_1_o = rd_view[a1_i];
  assign reg_data_2_o = rd_view[a2_i];
endmodule

// File: tb/tb_riscv_reg_file.sv
// tb_riscv_reg_file: randomized and directed checks of riscv_reg_file against an array model.
module tb_riscv_reg_file;
  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic [4:0]  a1_i = '0, a2_i = '0, a3_i = '0;
  logic [31:0] wd3_i = '0;
  logic        we3_i = 1'b0;
  logic [31:0] reg_data_1_o, reg_data_2_o;
  int checks = 0;
  int passed = 0;
  logic [31:0] model [32];

  riscv_reg_file dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .a1_i(a1_i), .a2_i(a2_i), .a3_i(a3_i),
    .wd3_i(wd3_i), .we3_i(we3_i),
    .reg_data_1_o(reg_data_1_o), .reg_data_2_o(reg_data_2_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mread(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : model[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  task automatic test_reset();
    model_clear();
    reset_i = 1'b0;
    a1_i = 5'd3; a2_i = 5'd17;
    @(posedge clk_i); #1;
    checks++;
    if (reg_data_1_o !== 32'd0 || reg_data_2_o !== 32'd0)
      $display("FAIL reset_hold: got %h/%h want 0/0", reg_data_1_o, reg_data_2_o);
    else passed++;
    @(negedge clk_i);
    reset_i = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk_i);
      a1_i = 5'(i); a2_i = 5'(i);
      #1;
      checks++;
      if (reg_data_1_o !== 32'd0 || reg_data_2_o !== 32'd0)
        $display("FAIL reset_sweep[%0d]: got %h/%h want 0/0", i, reg_data_1_o, reg_data_2_o);
      else passed++;
    end
  endtask

  task automatic test_write_sweep();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk_i);
      we3_i = 1'b1;
      a1_i = 5'(i); a2_i = 5'(i); a3_i = 5'(i); wd3_i = 32'(i);
      @(posedge clk_i);
      if (i != 0) model[i] = 32'(i);
      #1;
      checks++;
      if (reg_data_1_o !== mread(5'(i)) || reg_data_2_o !== mread(5'(i)))
        $display("FAIL write_sweep[%0d]: got %h/%h want %h", i, reg_data_1_o, reg_data_2_o, mread(5'(i)));
      else passed++;
    end
    @(negedge clk_i);
    we3_i = 1'b0;
  endtask

  task automatic test_we_off();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk_i);
      we3_i = 1'b0;
      a1_i = 5'(i); a2_i = 5'(i); a3_i = 5'(i); wd3_i = 32'd100;
      @(posedge clk_i); #1;
      checks++;
      if (reg_data_1_o !== mread(5'(i)) || reg_data_2_o !== mread(5'(i)))
        $display("FAIL we_off[%0d]: got %h/%h want %h", i, reg_data_1_o, reg_data_2_o, mread(5'(i)));
      else passed++;
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk_i);
    we3_i = 1'b1; a3_i = 5'd0; wd3_i = 32'd1; a1_i = 5'd0; a2_i = 5'd0;
    @(posedge clk_i); #1;
    checks++;
    if (reg_data_1_o !== 32'd0 || reg_data_2_o !== 32'd0)
      $display("FAIL zero_reg: got %h/%h want 0/0", reg_data_1_o, reg_data_2_o);
    else passed++;
    @(negedge clk_i);
    we3_i = 1'b0;
  endtask

  task automatic test_independent();
    @(negedge clk_i);
    a1_i = 5'd5; a2_i = 5'd31;
    #1;
    checks++;
    if (reg_data_1_o !== mread(5'd5) || reg_data_2_o !== mread(5'd31))
      $display("FAIL independent: got %h/%h want %h/%h", reg_data_1_o, reg_data_2_o, mread(5'd5), mread(5'd31));
    else passed++;
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk_i);
      a1_i = 5'($urandom_range(0, 31));
      a2_i = ($urandom_range(0, 3) == 0) ? a1_i : 5'($urandom_range(0, 31));
      a3_i = ($urandom_range(0, 4) == 0) ? a1_i : 5'($urandom_range(0, 31));
      wd3_i = $urandom;
      we3_i = 1'($urandom_range(0, 1));
      #1;
      e1 = mread(a1_i); e2 = mread(a2_i);
      checks++;
      if (reg_data_1_o !== e1 || reg_data_2_o !== e2)
        $display("FAIL rand_pre[%0d]: got %h/%h want %h/%h", n, reg_data_1_o, reg_data_2_o, e1, e2);
      else passed++;
      @(posedge clk_i);
      if (we3_i && a3_i != 5'd0) model[a3_i] = wd3_i;
      #1;
      e1 = mread(a1_i); e2 = mread(a2_i);
      checks++;
      if (reg_data_1_o !== e1 || reg_data_2_o !== e2)
        $display("FAIL rand_post[%0d]: got %h/%h want %h/%h", n, reg_data_1_o, reg_data_2_o, e1, e2);
      else passed++;
    end
    @(negedge clk_i);
    we3_i = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk_i);
    we3_i = 1'b0; a1_i = 5'd5; a2_i = 5'd31;
    #2;
    checks++;
    if (reg_data_1_o !== mread(5'd5) || reg_data_2_o !== mread(5'd31))
      $display("FAIL async_pre: got %h/%h want %h/%h", reg_data_1_o, reg_data_2_o, mread(5'd5), mread(5'd31));
    else passed++;
    reset_i = 1'b0;
    model_clear();
    #1;
    checks++;
    if (reg_data_1_o !== 32'd0 || reg_data_2_o !== 32'd0)
      $display("FAIL async_drop: got %h/%h want 0/0", reg_data_1_o, reg_data_2_o);
    else passed++;
    #1 reset_i = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk_i);
      a1_i = 5'(i); a2_i = 5'(31 - i);
      #1;
      checks++;
      if (reg_data_1_o !== 32'd0 || reg_data_2_o !== 32'd0)
        $display("FAIL async_sweep[%0d]: got %h/%h want 0/0", i, reg_data_1_o, reg_data_2_o);
      else passed++;
    end
  endtask

  task automatic test_reset_on_edge();
    @(negedge clk_i);
    we3_i = 1'b1; a3_i = 5'd7; wd3_i = 32'hDEAD_BEEF; a1_i = 5'd7; a2_i = 5'd7;
    @(posedge clk_i);
    reset_i = 1'b0;
    model_clear();
    #1;
    checks++;
    if (reg_data_1_o !== 32'd0 || reg_data_2_o !== 32'd0)
      $display("FAIL reset_on_edge: got %h/%h want 0/0", reg_data_1_o, reg_data_2_o);
    else passed++;
    @(negedge clk_i);
    we3_i = 1'b0;
    reset_i = 1'b1;
    #1;
    checks++;
    if (reg_data_1_o !== 32'd0)
      $display("FAIL reset_on_edge_after: got %h want 0", reg_data_1_o);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_write_sweep();
    test_we_off();
    test_zero_reg();
    test_independent();
    test_random();
    test_async_reset();
    test_reset_on_edge();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
